// File: rtl/mem_line_if.sv
// Cache-controller <-> line-memory bus: request enables, line address/data and status.
interface mem_line_if #(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned LINE_WORDS  = 4,
   parameter int unsigned LINE_ADDR_W = 6
);
   logic                         RAMreadEnable;
   logic                         RAMwriteEnable;
   logic [LINE_ADDR_W-1:0]       lineAddr;
   logic [LINE_WORDS*DATA_W-1:0] lineIn;
   logic [LINE_WORDS*DATA_W-1:0] lineOut;
   logic                         busy;
   logic                         done;
   logic                         protoErr;

   modport master (
      output RAMreadEnable, RAMwriteEnable, lineAddr, lineIn,
      input  lineOut, busy, done, protoErr
   );

   modport slave (
      input  RAMreadEnable, RAMwriteEnable, lineAddr, lineIn,
      output lineOut, busy, done, protoErr
   );
endinterface

// File: rtl/mem_line_responder.sv
// Line-granular memory model: fixed access latency, then one word per cycle
// for line fetches and write-backs.
module mem_line_responder #(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned LINE_WORDS  = 4,
   parameter int unsigned LINE_ADDR_W = 6,
   parameter int unsigned ACCESS_LAT  = 2
) (
   input logic       clk,
   input logic       clr,
   mem_line_if.slave bus
);
   localparam int unsigned IDX_W    = $clog2(LINE_WORDS);
   localparam int unsigned MEM_AW   = LINE_ADDR_W + IDX_W;
   localparam int unsigned DEPTH    = 1 << MEM_AW;
   localparam int unsigned LINE_W   = LINE_WORDS * DATA_W;
   localparam int unsigned CNT_W    = 4;
   localparam int unsigned CNT_LOAD = (ACCESS_LAT == 0) ? 0 : ACCESS_LAT - 1;

   typedef enum logic [1:0] {IDLE, WAIT, XFER, DONE} state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [LINE_ADDR_W-1:0] addr_q, addr_d;
   logic [LINE_W-1:0]      line_in_q, line_in_d;
   logic [LINE_W-1:0]      line_out_q, line_out_d;
   logic                   is_wr_q, is_wr_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   proto_err_q, proto_err_d;

   logic                   mem_we_c;
   logic [MEM_AW-1:0]      mem_addr_c;
   logic [DATA_W-1:0]      mem_wdata_c;
   logic [DATA_W-1:0]      mem_q [DEPTH];

   // Next-state and datapath control
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      addr_d      = addr_q;
      line_in_d   = line_in_q;
      line_out_d  = line_out_q;
      is_wr_d     = is_wr_q;
      proto_err_d = 1'b0;
      mem_we_c    = 1'b0;
      mem_addr_c  = {addr_q, idx_q};
      mem_wdata_c = line_in_q[32'(idx_q)*DATA_W +: DATA_W];

      unique case (state_q)
         IDLE: begin
            if (bus.RAMwriteEnable || bus.RAMreadEnable) begin
               // A simultaneous read request is dropped; write-back wins.
               addr_d      = bus.lineAddr;
               is_wr_d     = bus.RAMwriteEnable;
               idx_d       = '0;
               proto_err_d = bus.RAMwriteEnable && bus.RAMreadEnable;
               if (bus.RAMwriteEnable) line_in_d = bus.lineIn;
               if (ACCESS_LAT == 0) begin
                  state_d = XFER;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_W'(CNT_LOAD);
               end
            end
         end
         WAIT: begin
            if (cnt_q == '0) state_d = XFER;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         XFER: begin
            if (is_wr_q) mem_we_c = 1'b1;
            else         line_out_d[32'(idx_q)*DATA_W +: DATA_W] = mem_q[mem_addr_c];
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(LINE_WORDS - 1)) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         addr_q      <= '0;
         line_in_q   <= '0;
         line_out_q  <= '0;
         is_wr_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         addr_q      <= addr_d;
         line_in_q   <= line_in_d;
         line_out_q  <= line_out_d;
         is_wr_q     <= is_wr_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         proto_err_q <= proto_err_d;
      end
   end

   // Storage keeps its contents across reset; an aborted write leaves earlier words in place.
   always_ff @(posedge clk) begin
      if (mem_we_c) mem_q[mem_addr_c] <= mem_wdata_c;
   end

   assign bus.lineOut  = line_out_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.protoErr = proto_err_q;
endmodule

// File: doc/mem_line_responder.md
MEM_LINE_RESPONDER -- requirements
Module: mem_line_responder

Interface
REQ-001 SHALL have parameter DATA_W, default 8, bits per memory word.
REQ-002 SHALL have parameter LINE_WORDS, default 4, words per cache line (power of two, 2..16).
REQ-003 SHALL have parameter LINE_ADDR_W, default 6, line address width; storage = 2^LINE_ADDR_W lines.
REQ-004 SHALL have parameter ACCESS_LAT, default 2, access-latency cycles before transfer (0..15).
REQ-005 SHALL have port clk  input  1  single clock, all state changes on rising edge.
REQ-006 SHALL have port clr  input  1  asynchronous active-low reset.
REQ-007 SHALL have port RAMreadEnable  input  1  line fetch request from cache controller.
REQ-008 SHALL have port RAMwriteEnable  input  1  line write-back request from cache controller.
REQ-009 SHALL have port lineAddr  input  LINE_ADDR_W  target line address.
REQ-010 SHALL have port lineIn  input  LINE_WORDS*DATA_W  write-back line; word 0 in bits [DATA_W-1:0].
REQ-011 SHALL have port lineOut  output  LINE_WORDS*DATA_W  fetched line, same word ordering.
REQ-012 SHALL have port busy  output  1  request in progress.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port protoErr  output  1  one-cycle pulse, both enables sampled high together.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, XFER, DONE.
REQ-016 IDLE: sample enables each edge; write enable high -> capture lineAddr and lineIn, go WAIT (XFER if ACCESS_LAT=0); read enable only -> capture lineAddr, same transition; neither -> stay.
REQ-017 Both enables high in IDLE: SHALL treat as write-back, ignore read, pulse protoErr the following cycle.
REQ-018 WAIT: SHALL remain exactly ACCESS_LAT cycles via down-counter, then go XFER.
REQ-019 XFER: SHALL move one word per cycle, word index 0..LINE_WORDS-1; write = store captured word at {lineAddr, idx}; read = load word into lineOut slot idx.
REQ-020 XFER SHALL go DONE on the edge transferring word LINE_WORDS-1; DONE lasts one cycle then IDLE.
REQ-021 done SHALL be high only in DONE; busy SHALL be high in WAIT, XFER, DONE.
REQ-022 Total: done high in the cycle after edge N = ACCESS_LAT+LINE_WORDS counted from sampling edge (defaults: N=6); next request sampled at edge N+1 earliest.
REQ-023 Enables SHALL be ignored while busy; lineAddr/lineIn changes after sampling SHALL not affect the operation.
REQ-024 lineOut SHALL hold the last fully fetched line until the next read's XFER begins; unchanged by write-backs.
REQ-025 Word index SHALL wrap only within the line; no carry into line address.
REQ-026 Read after write to same line SHALL return written data.

Reset
REQ-027 clr low SHALL immediately force IDLE, busy=0, done=0, protoErr=0, lineOut=0, counters=0.
REQ-028 Reset mid-operation SHALL abort without done; words already written remain stored; storage array SHALL not be reset.
REQ-029 First request SHALL be sampled on the first rising edge with clr high.

Verification
REQ-030 Write line 5 = {0x44,0x33,0x22,0x11}, defaults -> busy next cycle, done one cycle after edge 6, busy low after edge 7.
REQ-031 Read line 5 after REQ-030 -> done after edge 6, lineOut=0x44332211, held through later write to line 6.
REQ-032 Both enables high, line 7 data 0xDEADBEEF -> protoErr one cycle, write performed, read of line 7 returns 0xDEADBEEF.
REQ-033 Pulse read enable during busy -> ignored, exactly one done per accepted request.
REQ-034 clr low during XFER of write to line 9 (after word 1) -> busy/done 0 at once; read of line 9 shows words 0-1 new, 2-3 old.
REQ-035 ACCESS_LAT=0, LINE_WORDS=2 -> done after edge 2 for both read and write.
